// File: rtl/sm83_dma_pkg.sv
// rtl/sm83_dma_pkg.sv - shared state type, constants and echo-RAM fold for the SM83 OAM DMA
package sm83_dma_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    XFER  = 2'd2
  } dma_state_t;

  localparam logic [15:0] DMA_REG_ADDR  = 16'hFF46;
  localparam int unsigned DMA_OAM_LEN   = 160;
  localparam logic [7:0]  DMA_ECHO_BASE = 8'hE0;
  localparam logic [7:0]  DMA_HI_PAGE   = 8'hFF;

  // Source pages E0..FF alias work RAM at C0..DF.
  function automatic logic [7:0] dma_src_eff(input logic [7:0] src);
    return (src >= DMA_ECHO_BASE) ? (src - 8'h20) : src;
  endfunction

endpackage

// File: rtl/sm83_dma_bus_mux.sv
// rtl/sm83_dma_bus_mux.sv - combinational CPU/DMA external-bus gating and CPU read-data return
module sm83_dma_bus_mux
  import sm83_dma_pkg::*;
#(
  parameter logic [15:0] REG_ADDR = DMA_REG_ADDR
) (
  input  logic        dma_active,
  input  logic [15:0] dma_addr,
  input  logic [7:0]  reg_rdata,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_rd,
  input  logic        cpu_wr,
  input  logic [7:0]  cpu_dout,
  output logic [7:0]  cpu_din,
  output logic [15:0] ext_addr,
  output logic        ext_rd,
  output logic        ext_wr,
  output logic [7:0]  ext_dout,
  input  logic [7:0]  ext_din
);

  logic hi_page;
  logic dma_owns;
  logic reg_hit;

  // IO/HRAM stays reachable during a copy; everything else belongs to the DMA.
  assign hi_page  = (cpu_addr[15:8] == DMA_HI_PAGE);
  assign dma_owns = dma_active && !hi_page;
  assign reg_hit  = (cpu_addr == REG_ADDR);

  always_comb begin
    ext_addr = cpu_addr;
    ext_rd   = cpu_rd;
    ext_wr   = cpu_wr;
    ext_dout = cpu_dout;
    cpu_din  = ext_din;
    if (dma_owns) begin
      ext_addr = dma_addr;
      ext_rd   = 1'b1;
      ext_wr   = 1'b0;
      ext_dout = 8'h00;
      cpu_din  = 8'hFF;
    end else if (reg_hit) begin
      cpu_din  = reg_rdata;
    end
  end

endmodule

// File: rtl/sm83_oam_dma.sv
// rtl/sm83_oam_dma.sv - OAM DMA sequencer and bus arbiter; SM83_DMA_READBACK_EN makes FF46 readable
module sm83_oam_dma
  import sm83_dma_pkg::*;
#(
  parameter int unsigned OAM_LEN  = DMA_OAM_LEN,
  parameter logic [15:0] REG_ADDR = DMA_REG_ADDR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        t1,
  input  logic        t2,
  input  logic        t3,
  input  logic        t4,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_rd,
  input  logic        cpu_wr,
  input  logic [7:0]  cpu_dout,
  output logic [7:0]  cpu_din,
  output logic [15:0] ext_addr,
  output logic        ext_rd,
  output logic        ext_wr,
  output logic [7:0]  ext_dout,
  input  logic [7:0]  ext_din,
  output logic [7:0]  oam_addr,
  output logic [7:0]  oam_wdata,
  output logic        oam_we,
  output logic        dma_active
);

  localparam logic [7:0] LAST_IDX = 8'(OAM_LEN - 1);

  dma_state_t state;
  logic [7:0] src;
  logic [7:0] xfer_src;
  logic [7:0] idx;
  logic       m_end;
  logic       trigger;
  logic       last_byte;
  logic [7:0] reg_rdata;

  // A malformed strobe pattern must never advance the copy.
  assign m_end     = t4 && !(t1 || t2 || t3);
  assign trigger   = m_end && cpu_wr && (cpu_addr == REG_ADDR);
  assign last_byte = (idx == LAST_IDX);

`ifdef SM83_DMA_READBACK_EN
  assign reg_rdata = src;
`else
  assign reg_rdata = 8'hFF;
`endif

  // xfer_src is the page of the copy in flight, so a restart can update src
  // while the old copy keeps running through START.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      src        <= 8'hFF;
      xfer_src   <= 8'h00;
      idx        <= 8'h00;
      dma_active <= 1'b0;
    end else if (m_end) begin
      if (dma_active) begin
        idx <= idx + 8'd1;
        if (last_byte) dma_active <= 1'b0;
      end
      if (trigger) begin
        src   <= cpu_dout;
        state <= START;
      end else begin
        case (state)
          START: begin
            idx        <= 8'h00;
            xfer_src   <= dma_src_eff(src);
            dma_active <= 1'b1;
            state      <= XFER;
          end
          XFER: begin
            if (last_byte) state <= IDLE;
          end
          default: state <= state;
        endcase
      end
    end
  end

  assign oam_we    = dma_active && m_end;
  assign oam_addr  = idx;
  assign oam_wdata = ext_din;

  sm83_dma_bus_mux #(
    .REG_ADDR (REG_ADDR)
  ) u_bus_mux (
    .dma_active (dma_active),
    .dma_addr   ({xfer_src, idx}),
    .reg_rdata  (reg_rdata),
    .cpu_addr   (cpu_addr),
    .cpu_rd     (cpu_rd),
    .cpu_wr     (cpu_wr),
    .cpu_dout   (cpu_dout),
    .cpu_din    (cpu_din),
    .ext_addr   (ext_addr),
    .ext_rd     (ext_rd),
    .ext_wr     (ext_wr),
    .ext_dout   (ext_dout),
    .ext_din    (ext_din)
  );

endmodule

// File: tb/tb_sm83_oam_dma.sv
// tb/tb_sm83_oam_dma.sv - self-checking bench for sm83_oam_dma
module tb_sm83_oam_dma;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        t1 = 1'b0, t2 = 1'b0, t3 = 1'b0, t4 = 1'b0;
  logic [15:0] cpu_addr = 16'h0000;
  logic        cpu_rd = 1'b0, cpu_wr = 1'b0;
  logic [7:0]  cpu_dout = 8'h00;
  logic [7:0]  cpu_din;
  logic [15:0] ext_addr;
  logic        ext_rd, ext_wr;
  logic [7:0]  ext_dout;
  logic [7:0]  ext_din;
  logic [7:0]  oam_addr, oam_wdata;
  logic        oam_we, dma_active;

  int passed = 0;
  int failed = 0;
  int total = 0;
  int mc = 0;
  logic [15:0] sched [int];
  logic [7:0]  exp_src = 8'hFF;

`ifdef SM83_DMA_READBACK_EN
  localparam bit READBACK = 1'b1;
`else
  localparam bit READBACK = 1'b0;
`endif

  always #5 clk = ~clk;

  sm83_oam_dma dut (
    .clk        (clk),
    .reset      (reset),
    .t1         (t1),
    .t2         (t2),
    .t3         (t3),
    .t4         (t4),
    .cpu_addr   (cpu_addr),
    .cpu_rd     (cpu_rd),
    .cpu_wr     (cpu_wr),
    .cpu_dout   (cpu_dout),
    .cpu_din    (cpu_din),
    .ext_addr   (ext_addr),
    .ext_rd     (ext_rd),
    .ext_wr     (ext_wr),
    .ext_dout   (ext_dout),
    .ext_din    (ext_din),
    .oam_addr   (oam_addr),
    .oam_wdata  (oam_wdata),
    .oam_we     (oam_we),
    .dma_active (dma_active)
  );

  function automatic logic [7:0] mem_byte(input logic [15:0] a);
    return a[7:0] ^ {a[10:8], a[15:11]} ^ 8'h5A;
  endfunction

  assign ext_din = mem_byte(ext_addr);

  function automatic logic [7:0] echo_fold(input logic [7:0] v);
    return (v >= 8'hE0) ? (v - 8'h20) : v;
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s mc=%0d observed=%0h expected=%0h", tag, mc, obs, exp);
    end
  endtask

  // A write to FF46 in M-cycle n schedules byte k at M-cycle n+2+k and
  // cancels whatever the previous copy had planned from n+2 on.
  task automatic start_copy(input int n, input logic [7:0] v);
    int drop[$];
    foreach (sched[k]) if (k >= n + 2) drop.push_back(k);
    foreach (drop[i]) sched.delete(drop[i]);
    for (int k = 0; k < 160; k++) sched[n + 2 + k] = {echo_fold(v), 8'(k)};
    exp_src = v;
  endtask

  task automatic check_phase(input int p);
    logic        act, cpu_side;
    logic [15:0] ent, ea;
    logic [7:0]  rb;
    act = (sched.exists(mc) != 0);
    ent = act ? sched[mc] : 16'h0000;
    cpu_side = !act || (cpu_addr[15:8] == 8'hFF);
    ea = cpu_side ? cpu_addr : ent;
    chk("dma_active", 16'(dma_active), 16'(act));
    chk("ext_addr", ext_addr, ea);
    chk("ext_rd", 16'(ext_rd), 16'(cpu_side ? cpu_rd : 1'b1));
    chk("ext_wr", 16'(ext_wr), 16'(cpu_side ? cpu_wr : 1'b0));
    if (cpu_side && cpu_wr) chk("ext_dout", 16'(ext_dout), 16'(cpu_dout));
    chk("oam_we", 16'(oam_we), 16'(act && (p == 4)));
    if (act && p == 4) begin
      chk("oam_addr", 16'(oam_addr), 16'(ent[7:0]));
      chk("oam_wdata", 16'(oam_wdata), 16'(mem_byte(ea)));
    end
    if (p == 4 && cpu_rd) begin
      if (!cpu_side) rb = 8'hFF;
      else if (cpu_addr == 16'hFF46) rb = READBACK ? exp_src : 8'hFF;
      else rb = mem_byte(cpu_addr);
      chk("cpu_din", 16'(cpu_din), 16'(rb));
    end
  endtask

  task automatic mcycle(input logic [15:0] a, input logic r, input logic w,
                        input logic [7:0] d, input bit kill);
    for (int p = 1; p <= 4; p++) begin
      @(negedge clk);
      if (p == 1) begin
        cpu_addr = a;
        cpu_rd   = r;
        cpu_wr   = w;
        cpu_dout = d;
        if (w && a == 16'hFF46) start_copy(mc, d);
      end
      t1 = (p == 1);
      t2 = (p == 2);
      t3 = (p == 3);
      t4 = (p == 4);
      if (kill && p == 2) begin
        #2;
        reset = 1'b0;
        sched.delete();
        exp_src = 8'hFF;
      end
      #1 check_phase(p);
    end
    mc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) mcycle(16'h0000, 1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic rand_op();
    logic [15:0] a;
    int k;
    a = 16'($urandom);
    if ($urandom_range(0, 3) == 0) a[15:8] = 8'hFF;
    if (a == 16'hFF46) a = 16'hFF80;
    k = int'($urandom_range(0, 2));
    mcycle(a, k == 1, k == 2, 8'($urandom), 1'b0);
  endtask

  task automatic dma_write(input logic [7:0] v);
    mcycle(16'hFF46, 1'b0, 1'b1, v, 1'b0);
  endtask

  initial begin
    // reset state: bus passes the CPU through, FF46 reads FF
    mcycle(16'h1234, 1'b1, 1'b0, 8'h00, 1'b0);
    mcycle(16'hFF46, 1'b1, 1'b0, 8'h00, 1'b0);
    reset = 1'b1;
    for (int i = 0; i < 6; i++) rand_op();

    // plain copy from C100 and echo-folded copy from E300
    dma_write(8'hC1);
    idle(165);
    dma_write(8'hE3);
    idle(165);

    // arbitration during XFER
    dma_write(8'($urandom_range(8'h80, 8'hDF)));
    idle(10);
    mcycle(16'h8000, 1'b1, 1'b0, 8'h00, 1'b0);
    mcycle(16'hC000, 1'b0, 1'b1, 8'hAB, 1'b0);
    mcycle(16'hFF80, 1'b1, 1'b0, 8'h00, 1'b0);
    mcycle(16'hFF81, 1'b0, 1'b1, 8'h3C, 1'b0);
    for (int i = 0; i < 155; i++) rand_op();

    // restart at idx 0x40
    dma_write(8'hC0);
    idle(1 + 8'h40);
    dma_write(8'hD0);
    idle(170);

    // restart coinciding with the final byte
    dma_write(8'hC5);
    idle(160);
    dma_write(8'hC6);
    idle(165);

    // reset mid-transfer at idx 0x20
    dma_write(8'($urandom_range(0, 8'hDF)));
    idle(1 + 8'h20);
    mcycle(16'h0000, 1'b0, 1'b0, 8'h00, 1'b1);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) rand_op();
    mcycle(16'hFF46, 1'b1, 1'b0, 8'h00, 1'b0);

    // source readback
    dma_write(8'h12);
    mcycle(16'hFF46, 1'b1, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 165; i++) rand_op();

    // random sources with random CPU traffic
    for (int j = 0; j < 3; j++) begin
      dma_write(8'($urandom));
      for (int i = 0; i < 170; i++) rand_op();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
